// File: rtl/ahb_mtx_pkg.sv
// Shared AHB encodings for the bus matrix arbiters: HTRANS/HBURST values and
// the fixed-length burst to remaining-beat mapping.
package ahb_mtx_pkg;

  typedef enum logic [1:0] {
    TRN_IDLE   = 2'b00,
    TRN_BUSY   = 2'b01,
    TRN_NONSEQ = 2'b10,
    TRN_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    BUR_SINGLE = 3'b000,
    BUR_INCR   = 3'b001,
    BUR_WRAP4  = 3'b010,
    BUR_INCR4  = 3'b011,
    BUR_WRAP8  = 3'b100,
    BUR_INCR8  = 3'b101,
    BUR_WRAP16 = 3'b110,
    BUR_INCR16 = 3'b111
  } hburst_t;

  typedef logic [1:0] prio_t;

  // Beats still to come after the NONSEQ beat, minus one, so that the
  // final SEQ beat sees remain==0 and releases the hold.
  function automatic logic [3:0] burst_remain(input logic [2:0] hburst);
    case (hburst)
      BUR_INCR16, BUR_WRAP16: burst_remain = 4'd14;
      BUR_INCR8,  BUR_WRAP8:  burst_remain = 4'd6;
      BUR_INCR4,  BUR_WRAP4:  burst_remain = 4'd2;
      BUR_SINGLE, BUR_INCR:   burst_remain = 4'd0;
      default:                burst_remain = 'x;
    endcase
  endfunction

endpackage

// File: rtl/ahb_mtx_burst_tracker.sv
// Tracks the burst in flight on a matrix output and decides whether the
// arbitration must be held for the next beat (next_hold).
module ahb_mtx_burst_tracker
  import ahb_mtx_pkg::*;
#(
  parameter int INCR_HOLD_BEATS = 4,
  parameter int EARLY_INCR_MAX  = 1
)(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HREADYM,
  input  logic       HSELM,
  input  logic [1:0] HTRANSM,
  input  logic [2:0] HBURSTM,
  output logic       next_hold
);

  localparam int ECW = (EARLY_INCR_MAX < 1) ? 1 : $clog2(EARLY_INCR_MAX + 1);
  localparam logic [ECW-1:0] EARLY_MAX   = ECW'(EARLY_INCR_MAX);
  localparam logic [3:0]     INCR_REMAIN = 4'(INCR_HOLD_BEATS - 2);

  logic [3:0]     remain_q, nxt_remain;
  logic           hold_q, nxt_hold;
  logic [ECW-1:0] early_q, nxt_early;

  always_comb begin
    nxt_remain = remain_q;
    nxt_hold   = hold_q;
    if (!HSELM) begin
      nxt_remain = '0;
      nxt_hold   = 1'b0;
    end else begin
      case (HTRANSM)
        TRN_IDLE: begin
          nxt_remain = '0;
          nxt_hold   = 1'b0;
        end
        TRN_BUSY: ;
        TRN_SEQ: begin
          if (remain_q == '0) nxt_hold = 1'b0;
          else                nxt_remain = remain_q - 4'd1;
        end
        TRN_NONSEQ: begin
          case (HBURSTM)
            BUR_SINGLE: begin
              nxt_remain = '0;
              nxt_hold   = 1'b0;
            end
            // Undefined-length INCR only gets a short hold, and a master
            // chaining them back to back eventually loses it.
            BUR_INCR: begin
              if (early_q == EARLY_MAX) begin
                nxt_remain = '0;
                nxt_hold   = 1'b0;
              end else begin
                nxt_remain = INCR_REMAIN;
                nxt_hold   = 1'b1;
              end
            end
            default: begin
              nxt_remain = burst_remain(HBURSTM);
              nxt_hold   = 1'b1;
            end
          endcase
        end
        default: begin
          nxt_remain = 'x;
          nxt_hold   = 1'bx;
        end
      endcase
    end

    nxt_early = early_q;
    if (!nxt_hold)
      nxt_early = '0;
    else if (hold_q && (HTRANSM == TRN_NONSEQ) && (early_q != EARLY_MAX))
      nxt_early = early_q + 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      remain_q <= '0;
      hold_q   <= 1'b0;
      early_q  <= '0;
    end else if (HREADYM) begin
      remain_q <= nxt_remain;
      hold_q   <= nxt_hold;
      early_q  <= nxt_early;
    end
  end

  assign next_hold = nxt_hold;

endmodule

// File: rtl/ahb_mtx_arbiter_rr_param.sv
// Round-robin output-stage arbiter for one AHB matrix target, with burst/lock
// hold. Define AHB_MTX_ARB_QOS_EN to add the prio_port QoS filter.
module ahb_mtx_arbiter_rr_param
  import ahb_mtx_pkg::*;
#(
  parameter int                   NUM_PORTS       = 5,
  parameter logic [NUM_PORTS-1:0] PORT_MASK       = '1,
  parameter int                   PORT_W          = 3,
  parameter int                   INCR_HOLD_BEATS = 4,
  parameter int                   EARLY_INCR_MAX  = 1
)(
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_PORTS-1:0]   req_port,
`ifdef AHB_MTX_ARB_QOS_EN
  input  logic [2*NUM_PORTS-1:0] prio_port,
`endif
  input  logic                   HREADYM,
  input  logic                   HSELM,
  input  logic [1:0]             HTRANSM,
  input  logic [2:0]             HBURSTM,
  input  logic                   HMASTLOCKM,
  output logic [PORT_W-1:0]      addr_in_port,
  output logic                   no_port
);

  localparam int IDXW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic                 next_hold;
  logic [NUM_PORTS-1:0] valid, cand;
  logic                 low_found, rr_found;
  logic [PORT_W-1:0]    low_idx, rr_idx, nxt_addr;
  logic                 nxt_no_port;

  ahb_mtx_burst_tracker #(
    .INCR_HOLD_BEATS (INCR_HOLD_BEATS),
    .EARLY_INCR_MAX  (EARLY_INCR_MAX)
  ) u_burst_tracker (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HREADYM   (HREADYM),
    .HSELM     (HSELM),
    .HTRANSM   (HTRANSM),
    .HBURSTM   (HBURSTM),
    .next_hold (next_hold)
  );

  assign valid = req_port & PORT_MASK;

`ifdef AHB_MTX_ARB_QOS_EN
  prio_t max_prio;

  always_comb begin
    max_prio = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (valid[i[IDXW-1:0]] && (prio_port[2*i +: 2] > max_prio))
        max_prio = prio_port[2*i +: 2];
    cand = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      cand[i[IDXW-1:0]] = valid[i[IDXW-1:0]] && (prio_port[2*i +: 2] == max_prio);
  end
`else
  assign cand = valid;
`endif

  // The rotation starts one past the current grant, so the current port
  // is never its own round-robin successor.
  always_comb begin : search_c
    int p;
    p         = 0;
    low_found = 1'b0;
    low_idx   = '0;
    rr_found  = 1'b0;
    rr_idx    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!low_found && cand[i[IDXW-1:0]]) begin
        low_found = 1'b1;
        low_idx   = PORT_W'(i);
      end
    end
    for (int k = 1; k < NUM_PORTS; k++) begin
      p = int'(addr_in_port) + k;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      if (!rr_found && cand[p[IDXW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = PORT_W'(p);
      end
    end
  end

  always_comb begin
    nxt_addr    = addr_in_port;
    nxt_no_port = no_port;
    if (HMASTLOCKM || next_hold) begin
      nxt_no_port = 1'b0;
    end else if (no_port) begin
      if (low_found) begin
        nxt_addr    = low_idx;
        nxt_no_port = 1'b0;
      end
    end else if (rr_found) begin
      nxt_addr = rr_idx;
    end else if (!HSELM) begin
      nxt_no_port = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_in_port <= '0;
      no_port      <= 1'b1;
    end else if (HREADYM) begin
      addr_in_port <= nxt_addr;
      no_port      <= nxt_no_port;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESETn && !no_port)
      assert (PORT_MASK[addr_in_port[IDXW-1:0]]);
  end

endmodule

// File: tb/tb_ahb_mtx_arbiter_rr_param.sv
// Directed bench for ahb_mtx_arbiter_rr_param (5 ports, mask 5'b11101) with a
// queue of expected grants checked one beat after each stimulus.
module tb_ahb_mtx_arbiter_rr_param;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] INCR8  = 3'b101;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [4:0] req_port;
  logic       HREADYM, HSELM, HMASTLOCKM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic [2:0] addr_in_port;
  logic       no_port;
`ifdef AHB_MTX_ARB_QOS_EN
  logic [9:0] prio_port;
`endif

  logic [3:0] exp_q[$];
  string      tag_q[$];
  int         n_assert = 0;
  int         n_fail   = 0;

  ahb_mtx_arbiter_rr_param #(
    .NUM_PORTS       (5),
    .PORT_MASK       (5'b11101),
    .PORT_W          (3),
    .INCR_HOLD_BEATS (4),
    .EARLY_INCR_MAX  (1)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req_port     (req_port),
`ifdef AHB_MTX_ARB_QOS_EN
    .prio_port    (prio_port),
`endif
    .HREADYM      (HREADYM),
    .HSELM        (HSELM),
    .HTRANSM      (HTRANSM),
    .HBURSTM      (HBURSTM),
    .HMASTLOCKM   (HMASTLOCKM),
    .addr_in_port (addr_in_port),
    .no_port      (no_port)
  );

  always #5 HCLK = ~HCLK;

  task automatic checkOutput();
    logic [3:0] e;
    string      t;
    n_assert++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("[TB] FAIL scoreboard_empty queue size got 0 expected >0");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_assert++;
      assert (addr_in_port === e[3:1]) else begin
        n_fail++;
        $error("[TB] FAIL %s addr_in_port got %0d expected %0d", t, addr_in_port, e[3:1]);
      end
      n_assert++;
      assert (no_port === e[0]) else begin
        n_fail++;
        $error("[TB] FAIL %s no_port got %0b expected %0b", t, no_port, e[0]);
      end
    end
  endtask

  task automatic applyStimulus(input logic [4:0] req, input logic sel,
                               input logic [1:0] trn, input logic [2:0] bur,
                               input logic lock, input logic rdy,
                               input logic [2:0] exp_addr, input logic exp_nop,
                               input string tag);
    req_port   = req;
    HSELM      = sel;
    HTRANSM    = trn;
    HBURSTM    = bur;
    HMASTLOCKM = lock;
    HREADYM    = rdy;
    exp_q.push_back({exp_addr, exp_nop});
    tag_q.push_back(tag);
    @(posedge HCLK);
    #1;
    checkOutput();
  endtask

  initial begin
    HRESETn    = 1'b0;
    req_port   = '0;
    HREADYM    = 1'b1;
    HSELM      = 1'b0;
    HTRANSM    = IDLE;
    HBURSTM    = SINGLE;
    HMASTLOCKM = 1'b0;
`ifdef AHB_MTX_ARB_QOS_EN
    prio_port  = '0;
`endif
    $display("[TB] start");
    repeat (2) @(posedge HCLK);
    #1;
    exp_q.push_back({3'd0, 1'b1}); tag_q.push_back("reset");
    checkOutput();
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Basic grant from idle, release and masked request
    applyStimulus(5'b00100, 0, IDLE, SINGLE, 0, 1, 3'd2, 0, "first_grant");
    applyStimulus(5'b00000, 0, IDLE, SINGLE, 0, 1, 3'd2, 1, "release");
    applyStimulus(5'b00010, 0, IDLE, SINGLE, 0, 1, 3'd2, 1, "masked_only");

    // Round-robin rotation, port 1 masked, HREADYM freeze
    applyStimulus(5'b00001, 0, IDLE,   SINGLE, 0, 1, 3'd0, 0, "rr_setup");
    applyStimulus(5'b11111, 1, NONSEQ, SINGLE, 0, 1, 3'd2, 0, "rr_a");
    applyStimulus(5'b11111, 1, NONSEQ, SINGLE, 0, 1, 3'd3, 0, "rr_b");
    applyStimulus(5'b11111, 1, NONSEQ, SINGLE, 0, 1, 3'd4, 0, "rr_c");
    applyStimulus(5'b11111, 1, NONSEQ, SINGLE, 0, 1, 3'd0, 0, "rr_wrap");
    applyStimulus(5'b11111, 1, NONSEQ, SINGLE, 0, 1, 3'd2, 0, "rr_skip1");
    applyStimulus(5'b11111, 1, NONSEQ, SINGLE, 0, 0, 3'd2, 0, "rr_wait");
    applyStimulus(5'b11111, 1, NONSEQ, SINGLE, 0, 1, 3'd3, 0, "rr_resume");

    // INCR8 from port 3 with BUSY and wait state, port 4 waiting
    applyStimulus(5'b01000, 0, IDLE,   SINGLE, 0, 1, 3'd3, 1, "b8_drop");
    applyStimulus(5'b01000, 0, IDLE,   SINGLE, 0, 1, 3'd3, 0, "b8_setup");
    applyStimulus(5'b11000, 1, NONSEQ, INCR8,  0, 1, 3'd3, 0, "b8_beat0");
    applyStimulus(5'b11000, 1, SEQ,    INCR8,  0, 1, 3'd3, 0, "b8_beat1");
    applyStimulus(5'b11000, 1, SEQ,    INCR8,  0, 1, 3'd3, 0, "b8_beat2");
    applyStimulus(5'b11000, 1, BUSY,   INCR8,  0, 1, 3'd3, 0, "b8_busy");
    applyStimulus(5'b11000, 1, SEQ,    INCR8,  0, 0, 3'd3, 0, "b8_wait");
    applyStimulus(5'b11000, 1, SEQ,    INCR8,  0, 1, 3'd3, 0, "b8_beat3");
    applyStimulus(5'b11000, 1, SEQ,    INCR8,  0, 1, 3'd3, 0, "b8_beat4");
    applyStimulus(5'b11000, 1, SEQ,    INCR8,  0, 1, 3'd3, 0, "b8_beat5");
    applyStimulus(5'b11000, 1, SEQ,    INCR8,  0, 1, 3'd3, 0, "b8_beat6");
    applyStimulus(5'b11000, 1, SEQ,    INCR8,  0, 1, 3'd4, 0, "b8_beat7");

    // Back-to-back short INCR bursts from port 0, port 2 waiting
    applyStimulus(5'b00001, 0, IDLE,   SINGLE, 0, 1, 3'd0, 0, "incr_setup");
    applyStimulus(5'b00101, 1, NONSEQ, INCR,   0, 1, 3'd0, 0, "incr_a0");
    applyStimulus(5'b00101, 1, SEQ,    INCR,   0, 1, 3'd0, 0, "incr_a1");
    applyStimulus(5'b00101, 1, SEQ,    INCR,   0, 1, 3'd0, 0, "incr_a2");
    applyStimulus(5'b00101, 1, NONSEQ, INCR,   0, 1, 3'd0, 0, "incr_b0");
    applyStimulus(5'b00101, 1, SEQ,    INCR,   0, 1, 3'd0, 0, "incr_b1");
    applyStimulus(5'b00101, 1, SEQ,    INCR,   0, 1, 3'd0, 0, "incr_b2");
    applyStimulus(5'b00101, 1, NONSEQ, INCR,   0, 1, 3'd2, 0, "incr_refused");

    // Locked transfers on port 4, then reset in the middle of a burst
    applyStimulus(5'b10000, 0, IDLE,   SINGLE, 0, 1, 3'd4, 0, "lock_setup");
    applyStimulus(5'b11111, 1, NONSEQ, SINGLE, 1, 1, 3'd4, 0, "lock_a");
    applyStimulus(5'b11111, 1, NONSEQ, SINGLE, 1, 1, 3'd4, 0, "lock_b");
    applyStimulus(5'b11111, 1, NONSEQ, SINGLE, 0, 1, 3'd0, 0, "lock_drop");
    applyStimulus(5'b11111, 1, NONSEQ, INCR4,  0, 1, 3'd0, 0, "rst_b0");
    applyStimulus(5'b11111, 1, SEQ,    INCR4,  0, 1, 3'd0, 0, "rst_b1");
    #2;
    HRESETn = 1'b0;
    #1;
    exp_q.push_back({3'd0, 1'b1}); tag_q.push_back("async_reset");
    checkOutput();
    @(negedge HCLK);
    HRESETn = 1'b1;
    applyStimulus(5'b00000, 0, IDLE, SINGLE, 0, 1, 3'd0, 1, "post_reset");
    applyStimulus(5'b00100, 1, SEQ,  INCR4,  0, 1, 3'd2, 0, "post_reset_nohold");

`ifdef AHB_MTX_ARB_QOS_EN
    // QoS: highest level wins, equal levels fall back to round-robin
    prio_port = 10'b01_01_01_01_01;
    applyStimulus(5'b00001, 0, IDLE,   SINGLE, 0, 1, 3'd0, 0, "qos_setup");
    prio_port = 10'b11_01_01_01_01;
    applyStimulus(5'b11101, 1, NONSEQ, SINGLE, 0, 1, 3'd4, 0, "qos_high");
    prio_port = 10'b01_01_01_01_01;
    applyStimulus(5'b11101, 1, NONSEQ, SINGLE, 0, 1, 3'd0, 0, "qos_equal");
`endif

    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("[TB] FAIL scoreboard_leftover size got %0d expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
